module_key_debounce: RTL and testbench
======================================

// Module: module_key_debounce
// PURPOSE
//  Front end of the keypad path: synchronises the raw 4x4 keypad lines, debounces them, and rejects multi-key presses.
//  Encodes a single stable press into a 4-bit key code and emits a one-cycle key_valid strobe per press.
//  Sits between the board pins (row/column) and module_teclado, clocked by the divided clock clk_div.
// PARAMETERS
//  DEBOUNCE_CYCLES  16   consecutive stable cycles required to accept a press or a release (>=2)
//  REPEAT_CYCLES    512  hold time before and between auto-repeat strobes (only with KEY_REPEAT_EN)
// PORTS
//  clk        in   1  block clock (clk_div in the system); single clock domain
//  rst        in   1  reset, asynchronous, active-high
//  row        in   4  raw keypad row lines, active-high, asynchronous to clk
//  column     in   4  raw keypad column lines, active-high, asynchronous to clk
//  key_code   out  4  code of the last accepted key; held until the next accepted key
//  key_valid  out  1  one-cycle strobe: key_code is new this cycle
//  key_held   out  1  high while the accepted key remains pressed (PRESSED state)
//  multi_err  out  1  one-cycle strobe: a stable non-one-hot pattern was rejected
// BEHAVIOUR
//  Reset: key_code=0, key_valid=0, key_held=0, multi_err=0, FSM=IDLE, counter=0, synchronisers cleared.
//  Sync: row and column each pass through a 2-FF synchroniser. All logic below uses the synced value s={row_s,column_s}.
//  Encoding: r=index of the row_s bit, c=index of the column_s bit. Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
//    Codes: digits map to their value 0-9; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
//  FSM states:
//   IDLE: if s!=0, latch snap<=s, cnt<=0, go to DB_PRESS.
//   DB_PRESS: if s!=snap, return to IDLE. Otherwise cnt++.
//    When cnt==DEBOUNCE_CYCLES-1 and both row_s and column_s are one-hot:
//     key_code<=enc(snap), key_valid=1 next cycle, go to PRESSED.
//    When cnt==DEBOUNCE_CYCLES-1 and the pattern is not one-hot: multi_err=1, go to WAIT_REL.
//   PRESSED: key_held=1. If s!=snap, cnt<=0 and go to DB_REL.
//   WAIT_REL: if s!=0, cnt<=0. If s==0, cnt++. At cnt==DEBOUNCE_CYCLES-1, go to IDLE.
//    No key_valid is issued in this state.
//   DB_REL: if s==snap, return to PRESSED (bounce). Else if s==0, cnt++; at DEBOUNCE_CYCLES-1 go to IDLE.
//    Else (a different key is pressed), go to WAIT_REL.
//  Latency: the first stable raw sample gives key_valid 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later.
//  Exactly one key_valid per press. A new press is only accepted after a debounced release.
//  Key_code is unchanged by a rejected press or a multi-key press.
//  Reset mid-operation: all state clears immediately. A key still held after reset deasserts is re-debounced
//   and produces one new key_valid.
//  Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1. The counter saturates and never wraps.
// CONFIGURATION
//  KEY_REPEAT_EN defined: in PRESSED, a second counter runs.
//   After REPEAT_CYCLES cycles it re-pulses key_valid with the same key_code, restarts, and repeats every REPEAT_CYCLES.
//   The repeat counter clears when the block leaves PRESSED.
//  KEY_REPEAT_EN undefined: no repeat counter is built. There is exactly one strobe per press.
// STRUCTURE
//  Package key_pkg:
//   typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, DB_REL, WAIT_REL} key_state_t
//   KEY_A..KEY_HASH code localparams
//   function onehot4_idx(), returning {valid, idx[1:0]}
//  Sub-module module_sync2ff (WIDTH param, async active-high reset to 0): instantiated for row and column.
// TESTING
//  1) Reset, then row=0001, column=0010, held 40 cycles -> one key_valid, key_code=2, key_held=1 until release.
//  2) Key '5' with 3 bounces of 4 cycles each before it settles -> exactly one key_valid, key_code=5,
//     timed from the last bounce edge.
//  3) row=0011, column=0001 stable 40 cycles -> one multi_err pulse, no key_valid, key_code unchanged.
//  4) Press '#' (row=1000, column=0100), release for 5 cycles, re-press -> only one key_valid, code 0xF.
//     After a release of >=DEBOUNCE_CYCLES, a re-press gives a second valid.
//  5) Assert rst while in PRESSED with key '0' held -> outputs go to 0 at once.
//     After rst falls, one new key_valid with code 0.
//  6) With KEY_REPEAT_EN defined, hold 'D' for 2000 cycles -> key_valid at ~19 cycles, then every 512 cycles.
//     Without the macro, only one strobe.

Source files
------------

// File: rtl/module_key_debounce_pkg.sv
// Shared keypad types: FSM state encoding, key code constants and one-hot/encode helpers.
package key_pkg;

  typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, DB_REL, WAIT_REL} key_state_t;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Returns {valid, idx}; valid only for exactly one bit set.
  function automatic logic [2:0] onehot4_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 3'b100;
      4'b0010: return 3'b101;
      4'b0100: return 3'b110;
      4'b1000: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_enc(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return KEY_1;
      4'h1: return KEY_2;
      4'h2: return KEY_3;
      4'h3: return KEY_A;
      4'h4: return KEY_4;
      4'h5: return KEY_5;
      4'h6: return KEY_6;
      4'h7: return KEY_B;
      4'h8: return KEY_7;
      4'h9: return KEY_8;
      4'hA: return KEY_9;
      4'hB: return KEY_C;
      4'hC: return KEY_STAR;
      4'hD: return KEY_0;
      4'hE: return KEY_HASH;
      default: return KEY_D;
    endcase
  endfunction

endpackage

// File: rtl/module_sync2ff.sv
// Two-flop synchroniser for asynchronous keypad lines, cleared by async reset.
module module_sync2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/module_key_debounce.sv
// Keypad front end: sync, debounce, multi-key rejection and key encoding.
// Optional auto-repeat of key_valid while held is built when KEY_REPEAT_EN is defined.
module module_key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  input  logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int CNT_SPAN = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW       = $clog2(CNT_SPAN) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] row_s, column_s;
  logic [7:0] s;

  module_sync2ff #(.WIDTH(4)) u_sync_row (.clk(clk), .rst(rst), .d(row),    .q(row_s));
  module_sync2ff #(.WIDTH(4)) u_sync_col (.clk(clk), .rst(rst), .d(column), .q(column_s));

  assign s = {row_s, column_s};

  key_state_t    state_q, state_d;
  logic [7:0]    snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          err_q, err_d;
  logic [2:0]    row_idx, col_idx;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rpt_q, rpt_d;
`endif

  assign row_idx = onehot4_idx(snap_q[7:4]);
  assign col_idx = onehot4_idx(snap_q[3:0]);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (s != '0) begin
          snap_d  = s;
          cnt_d   = '0;
          state_d = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (s != snap_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          cnt_d = '0;
          if (row_idx[2] && col_idx[2]) begin
            code_d  = key_enc(row_idx[1:0], col_idx[1:0]);
            valid_d = 1'b1;
            state_d = PRESSED;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_REL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (s != snap_q) begin
          cnt_d   = '0;
          state_d = DB_REL;
        end
`ifdef KEY_REPEAT_EN
        else if (rpt_q == RPT_LAST) begin
          valid_d = 1'b1;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
`endif
      end
      DB_REL: begin
        if (s == snap_q) begin
          state_d = PRESSED;
        end else if (s == '0) begin
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d   = '0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == PRESSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      err_q   <= err_d;
`ifdef KEY_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi_err = err_q;

endmodule

// File: tb/tb_module_key_debounce.sv
// Directed self-checking bench for module_key_debounce (DEBOUNCE_CYCLES=16, REPEAT_CYCLES=512).
module tb_module_key_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row = 4'b0000;
  logic [3:0] column = 4'b0000;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  int tests = 0;
  int fails = 0;
  int t = 0;
  int t0 = 0;
  int nvalid = 0;
  int nerr = 0;
  int first_valid = -1;
  int first_err = -1;
  int second_valid = -1;
  logic [3:0] last_code = 4'h0;

  module_key_debounce #(.DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(512)) dut (
    .clk(clk), .rst(rst), .row(row), .column(column),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  task automatic clear_counts();
    t0 = t; nvalid = 0; nerr = 0; first_valid = -1; first_err = -1; second_valid = -1;
  endtask

  // Advance n cycles, sampling outputs on each falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t++;
      if (key_valid === 1'b1) begin
        nvalid++;
        if (first_valid < 0) first_valid = t - t0;
        else if (second_valid < 0) second_valid = t - t0;
        last_code = key_code;
      end
      if (multi_err === 1'b1) begin
        nerr++;
        if (first_err < 0) first_err = t - t0;
      end
    end
  endtask

  task automatic set_keys(input logic [3:0] r, input logic [3:0] c);
    row = r; column = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_keys(4'b0000, 4'b0000);
    step(3);
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %0h expected 0", key_code); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", key_valid); end
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %0b expected 0", key_held); end
    tests++; if (multi_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b expected 0", multi_err); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single_press();
    clear_counts();
    set_keys(4'b0001, 4'b0010);
    step(40);
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL press2_count: got %0d expected 1", nvalid); end
    tests++; if (first_valid !== 19) begin fails++; $display("FAIL press2_latency: got %0d expected 19", first_valid); end
    tests++; if (key_code !== 4'h2) begin fails++; $display("FAIL press2_code: got %0h expected 2", key_code); end
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL press2_held: got %0b expected 1", key_held); end
    set_keys(4'b0000, 4'b0000);
    step(2);
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL release_held_late: got %0b expected 1", key_held); end
    step(1);
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL release_held_drop: got %0b expected 0", key_held); end
    step(30);
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL release_no_valid: got %0d expected 1", nvalid); end
  endtask

  task automatic test_bounce();
    clear_counts();
    for (int b = 0; b < 3; b++) begin
      set_keys(4'b0010, 4'b0010); step(4);
      set_keys(4'b0000, 4'b0000); step(4);
    end
    tests++; if (nvalid !== 0) begin fails++; $display("FAIL bounce_early_valid: got %0d expected 0", nvalid); end
    clear_counts();
    set_keys(4'b0010, 4'b0010);
    step(40);
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL bounce_count: got %0d expected 1", nvalid); end
    tests++; if (first_valid !== 19) begin fails++; $display("FAIL bounce_latency: got %0d expected 19", first_valid); end
    tests++; if (key_code !== 4'h5) begin fails++; $display("FAIL bounce_code: got %0h expected 5", key_code); end
    set_keys(4'b0000, 4'b0000);
    step(30);
  endtask

  task automatic test_multi_key();
    clear_counts();
    set_keys(4'b0011, 4'b0001);
    step(40);
    tests++; if (nerr !== 1) begin fails++; $display("FAIL multi_err_count: got %0d expected 1", nerr); end
    tests++; if (first_err !== 19) begin fails++; $display("FAIL multi_err_latency: got %0d expected 19", first_err); end
    tests++; if (nvalid !== 0) begin fails++; $display("FAIL multi_no_valid: got %0d expected 0", nvalid); end
    tests++; if (key_code !== 4'h5) begin fails++; $display("FAIL multi_code_kept: got %0h expected 5", key_code); end
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL multi_held: got %0b expected 0", key_held); end
    set_keys(4'b0000, 4'b0000);
    step(30);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    set_keys(4'b1000, 4'b0100);
    step(40);
    set_keys(4'b0000, 4'b0000);
    step(5);
    set_keys(4'b1000, 4'b0100);
    step(40);
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL short_release_count: got %0d expected 1", nvalid); end
    tests++; if (key_code !== 4'hF) begin fails++; $display("FAIL hash_code: got %0h expected f", key_code); end
    set_keys(4'b0000, 4'b0000);
    step(30);
    clear_counts();
    set_keys(4'b1000, 4'b0100);
    step(40);
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL repress_count: got %0d expected 1", nvalid); end
    tests++; if (first_valid !== 19) begin fails++; $display("FAIL repress_latency: got %0d expected 19", first_valid); end
    set_keys(4'b0000, 4'b0000);
    step(30);
  endtask

  task automatic test_debounce_boundary();
    clear_counts();
    set_keys(4'b0100, 4'b0100);
    step(16);
    set_keys(4'b0000, 4'b0000);
    step(30);
    tests++; if (nvalid !== 0) begin fails++; $display("FAIL hold16_valid: got %0d expected 0", nvalid); end
    tests++; if (key_code !== 4'hF) begin fails++; $display("FAIL hold16_code: got %0h expected f", key_code); end
    clear_counts();
    set_keys(4'b0100, 4'b0100);
    step(17);
    set_keys(4'b0000, 4'b0000);
    step(30);
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL hold17_valid: got %0d expected 1", nvalid); end
    tests++; if (last_code !== 4'h9) begin fails++; $display("FAIL hold17_code: got %0h expected 9", last_code); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    set_keys(4'b1000, 4'b0010);
    step(40);
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL pre_rst_held: got %0b expected 1", key_held); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL pre_rst_code: got %0h expected 0", key_code); end
    rst = 1'b1;
    #1;
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL mid_rst_held: got %0b expected 0", key_held); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %0b expected 0", key_valid); end
    step(3);
    clear_counts();
    rst = 1'b0;
    step(40);
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL post_rst_count: got %0d expected 1", nvalid); end
    tests++; if (first_valid !== 19) begin fails++; $display("FAIL post_rst_latency: got %0d expected 19", first_valid); end
    tests++; if (last_code !== 4'h0) begin fails++; $display("FAIL post_rst_code: got %0h expected 0", last_code); end
    set_keys(4'b0000, 4'b0000);
    step(30);
  endtask

  task automatic test_repeat();
    clear_counts();
    set_keys(4'b1000, 4'b1000);
    step(2000);
    tests++; if (first_valid !== 19) begin fails++; $display("FAIL hold_d_latency: got %0d expected 19", first_valid); end
    tests++; if (key_code !== 4'hD) begin fails++; $display("FAIL hold_d_code: got %0h expected d", key_code); end
`ifdef KEY_REPEAT_EN
    tests++; if (nvalid !== 4) begin fails++; $display("FAIL repeat_count: got %0d expected 4", nvalid); end
    tests++; if (second_valid !== 531) begin fails++; $display("FAIL repeat_period: got %0d expected 531", second_valid); end
`else
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL hold_d_count: got %0d expected 1", nvalid); end
`endif
    set_keys(4'b0000, 4'b0000);
    step(30);
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL hold_d_release: got %0b expected 0", key_held); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_back_to_back();
    test_debounce_boundary();
    test_reset_mid();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
